// File: rtl/xgmac_pkg.sv
// Shared definitions for the XGMAC IPIF register slave.
// Register offsets, access FSM encoding and interrupt bit positions.
package xgmac_pkg;

    localparam logic [3:0] REG_VERSION       = 4'd0;
    localparam logic [3:0] REG_CTRL          = 4'd1;
    localparam logic [3:0] REG_STATUS        = 4'd2;
    localparam logic [3:0] REG_INT_STATUS    = 4'd3;
    localparam logic [3:0] REG_INT_ENABLE    = 4'd4;
    localparam logic [3:0] REG_LINK_DOWN_CNT = 4'd5;
    localparam logic [3:0] REG_SCRATCH       = 4'd6;

    localparam int INT_XGMAC = 0;
    localparam int INT_LINK  = 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACK  = 2'd1,
        ST_WAIT = 2'd2
    } acc_state_e;

    typedef struct packed {
        logic        rnw;
        logic [3:0]  idx;
        logic [31:0] wdata;
    } bus_req_t;

    function automatic logic reg_mapped(input logic [3:0] idx);
        return idx <= REG_SCRATCH;
    endfunction

endpackage

// File: rtl/xgmac_edge_det.sv
// Rising/falling pulse generator against a one-cycle registered history.
// Pulses are high in the cycle the new level is first seen.
module xgmac_edge_det (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic rise,
    output logic fall
);

    logic d_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            d_q <= 1'b0;
        end else begin
            d_q <= d;
        end
    end

    assign rise = d & ~d_q;
    assign fall = ~d & d_q;

endmodule

// File: rtl/xgmac_ipif_slave.sv
// IPIF register slave for the XGMAC: control, status, interrupts,
// link-down counter and scratch, with a single-cycle ack handshake.
module xgmac_ipif_slave
    import xgmac_pkg::*;
#(
    parameter logic [31:0] C_VERSION = 32'h0001_0000,
    parameter int          C_CNT_W   = 16
) (
    input  logic        bus2ip_clk,
    input  logic        bus2ip_reset,
    input  logic        bus2ip_cs,
    input  logic        bus2ip_rnw,
    input  logic [31:0] bus2ip_addr,
    input  logic [31:0] bus2ip_data,
    output logic [31:0] ip2bus_data,
    output logic        ip2bus_rdack,
    output logic        ip2bus_wrack,
    output logic        ip2bus_error,
    input  logic        xgmacint,
    input  logic [7:0]  core_status,
    output logic        ctrl_tx_en,
    output logic        ctrl_rx_en,
    output logic        ctrl_loopback,
    output logic        irq
);

    localparam logic [C_CNT_W-1:0] CNT_MAX = '1;
    localparam logic [C_CNT_W-1:0] CNT_ONE = {{(C_CNT_W-1){1'b0}}, 1'b1};

    acc_state_e state_q;
    acc_state_e state_d;
    bus_req_t   req_q;

    logic ack_cyc;
    logic hit;
    logic wr_en;

    logic wr_ctrl;
    logic wr_int_status;
    logic wr_int_enable;
    logic wr_ldc;
    logic wr_scratch;

    logic [2:0]         ctrl_q;
    logic [7:0]         status_q;
    logic [1:0]         int_status_q;
    logic [1:0]         int_enable_q;
    logic [1:0]         int_set;
    logic [1:0]         int_clr;
    logic [C_CNT_W-1:0] ldc_q;
    logic [31:0]        scratch_q;
    logic               irq_q;
    logic [31:0]        rd_word;

    logic xg_rise;
    logic xg_fall_unused;
    logic link_rise_unused;
    logic link_fall;
    logic addr_unused;

    assign addr_unused = ^{bus2ip_addr[31:6], bus2ip_addr[1:0]};

    xgmac_edge_det u_xg_edge (
        .clk  (bus2ip_clk),
        .rst  (bus2ip_reset),
        .d    (xgmacint),
        .rise (xg_rise),
        .fall (xg_fall_unused)
    );

    xgmac_edge_det u_link_edge (
        .clk  (bus2ip_clk),
        .rst  (bus2ip_reset),
        .d    (core_status[0]),
        .rise (link_rise_unused),
        .fall (link_fall)
    );

    always_ff @(posedge bus2ip_clk) begin
        if (bus2ip_reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (bus2ip_cs) state_d = ST_ACK;
            ST_ACK:  state_d = ST_WAIT;
            ST_WAIT: if (!bus2ip_cs) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Request is frozen at the sampling edge so the ACK cycle
    // sees a stable address/direction/data.
    always_ff @(posedge bus2ip_clk) begin
        if (bus2ip_reset) begin
            req_q <= '0;
        end else if (state_q == ST_IDLE && bus2ip_cs) begin
            req_q.rnw   <= bus2ip_rnw;
            req_q.idx   <= bus2ip_addr[5:2];
            req_q.wdata <= bus2ip_data;
        end
    end

    assign ack_cyc = (state_q == ST_ACK);
    assign hit     = reg_mapped(req_q.idx);
    assign wr_en   = ack_cyc && !req_q.rnw && hit;

    always_comb begin
        ip2bus_rdack = 1'b0;
        ip2bus_wrack = 1'b0;
        ip2bus_error = 1'b0;
        ip2bus_data  = '0;
        if (ack_cyc) begin
            ip2bus_rdack = req_q.rnw;
            ip2bus_wrack = ~req_q.rnw;
            ip2bus_error = ~hit;
            if (req_q.rnw && hit) begin
                ip2bus_data = rd_word;
            end
        end
    end

    always_comb begin
        wr_ctrl       = 1'b0;
        wr_int_status = 1'b0;
        wr_int_enable = 1'b0;
        wr_ldc        = 1'b0;
        wr_scratch    = 1'b0;
        if (wr_en) begin
            unique case (1'b1)
                (req_q.idx == REG_CTRL):          wr_ctrl       = 1'b1;
                (req_q.idx == REG_INT_STATUS):    wr_int_status = 1'b1;
                (req_q.idx == REG_INT_ENABLE):    wr_int_enable = 1'b1;
                (req_q.idx == REG_LINK_DOWN_CNT): wr_ldc        = 1'b1;
                (req_q.idx == REG_SCRATCH):       wr_scratch    = 1'b1;
                default: ;
            endcase
        end
    end

    always_comb begin
        rd_word = '0;
        unique case (req_q.idx)
            REG_VERSION:       rd_word = C_VERSION;
            REG_CTRL:          rd_word = {29'b0, ctrl_q};
            REG_STATUS:        rd_word = {24'b0, status_q};
            REG_INT_STATUS:    rd_word = {30'b0, int_status_q};
            REG_INT_ENABLE:    rd_word = {30'b0, int_enable_q};
            REG_LINK_DOWN_CNT: rd_word = 32'(ldc_q);
            REG_SCRATCH:       rd_word = scratch_q;
            default:           rd_word = '0;
        endcase
    end

    // Set events are OR-ed in after the clear so they win a collision.
    always_comb begin
        int_set            = '0;
        int_set[INT_XGMAC] = xg_rise;
        int_set[INT_LINK]  = link_fall;
        int_clr            = wr_int_status ? req_q.wdata[1:0] : 2'b00;
    end

    always_ff @(posedge bus2ip_clk) begin
        if (bus2ip_reset) begin
            ctrl_q       <= '0;
            status_q     <= '0;
            int_status_q <= '0;
            int_enable_q <= '0;
            ldc_q        <= '0;
            scratch_q    <= '0;
            irq_q        <= 1'b0;
        end else begin
            status_q     <= core_status;
            int_status_q <= (int_status_q & ~int_clr) | int_set;
            irq_q        <= |(int_status_q & int_enable_q);
            if (wr_ctrl) ctrl_q <= req_q.wdata[2:0];
            if (wr_int_enable) int_enable_q <= req_q.wdata[1:0];
            if (wr_scratch) scratch_q <= req_q.wdata;
            if (link_fall) begin
                if (wr_ldc) begin
                    ldc_q <= CNT_ONE;
                end else if (ldc_q != CNT_MAX) begin
                    ldc_q <= ldc_q + CNT_ONE;
                end
            end else if (wr_ldc) begin
                ldc_q <= '0;
            end
        end
    end

    assign ctrl_tx_en    = ctrl_q[0];
    assign ctrl_rx_en    = ctrl_q[1];
    assign ctrl_loopback = ctrl_q[2];
    assign irq           = irq_q;

endmodule

// File: tb/tb_xgmac_ipif_slave.sv
// Bench for xgmac_ipif_slave: vector table plus ack scoreboard,
// with a narrow-counter second instance for saturation.
module tb_xgmac_ipif_slave;

    logic        clk = 1'b0;
    logic        rst;
    logic        cs;
    logic        rnw;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        xgmacint;
    logic [7:0]  core_status;

    logic [31:0] rd_data;
    logic        rdack, wrack, err;
    logic        tx_en, rx_en, lb;
    logic        irq;

    logic [31:0] s_rd_data;
    logic        s_rdack, s_wrack, s_err;
    logic        s_tx_en, s_rx_en, s_lb;
    logic        s_irq;

    always #5 clk = ~clk;

    xgmac_ipif_slave dut (
        .bus2ip_clk    (clk),
        .bus2ip_reset  (rst),
        .bus2ip_cs     (cs),
        .bus2ip_rnw    (rnw),
        .bus2ip_addr   (addr),
        .bus2ip_data   (wdata),
        .ip2bus_data   (rd_data),
        .ip2bus_rdack  (rdack),
        .ip2bus_wrack  (wrack),
        .ip2bus_error  (err),
        .xgmacint      (xgmacint),
        .core_status   (core_status),
        .ctrl_tx_en    (tx_en),
        .ctrl_rx_en    (rx_en),
        .ctrl_loopback (lb),
        .irq           (irq)
    );

    xgmac_ipif_slave #(.C_CNT_W(2)) dut2 (
        .bus2ip_clk    (clk),
        .bus2ip_reset  (rst),
        .bus2ip_cs     (cs),
        .bus2ip_rnw    (rnw),
        .bus2ip_addr   (addr),
        .bus2ip_data   (wdata),
        .ip2bus_data   (s_rd_data),
        .ip2bus_rdack  (s_rdack),
        .ip2bus_wrack  (s_wrack),
        .ip2bus_error  (s_err),
        .xgmacint      (xgmacint),
        .core_status   (core_status),
        .ctrl_tx_en    (s_tx_en),
        .ctrl_rx_en    (s_rx_en),
        .ctrl_loopback (s_lb),
        .irq           (s_irq)
    );

    typedef struct {
        logic        rd;
        logic [31:0] data;
        logic        err;
        logic        chk2;
        logic [31:0] data2;
    } exp_t;

    typedef struct {
        logic [31:0] addr;
        logic        rd;
        logic [31:0] wdata;
        logic [31:0] exp;
        logic        err;
    } vec_t;

    exp_t sb_q[$];
    exp_t e;
    vec_t tbl[20];
    int   vectors = 0;
    int   miscompares = 0;
    int   idle_checks = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, required %h", nm, act, exp);
        end
    endtask

    // Scoreboard: every ack pops one expectation.
    always @(negedge clk) begin
        if (rdack === 1'b1 || wrack === 1'b1) begin
            vectors++;
            if (sb_q.size() == 0) begin
                miscompares++;
                $display("FAIL spurious_ack: rdack=%b wrack=%b, none expected",
                         rdack, wrack);
            end else begin
                e = sb_q.pop_front();
                if (rdack !== e.rd || wrack !== !e.rd || rd_data !== e.data ||
                    err !== e.err || (e.chk2 && s_rd_data !== e.data2)) begin
                    miscompares++;
                    $display("FAIL ack@%0t: rd=%b data=%h err=%b data2=%h, required rd=%b data=%h err=%b data2=%h",
                             $time, rdack, rd_data, err, s_rd_data,
                             e.rd, e.data, e.err, e.data2);
                end
            end
        end else if (rst === 1'b0) begin
            idle_checks++;
            if (err !== 1'b0 || rd_data !== 32'h0) begin
                miscompares++;
                $display("FAIL idle_outputs@%0t: err=%b data=%h, required 0 0",
                         $time, err, rd_data);
            end
        end
    end

    task automatic wait_ack();
        bit got;
        got = 0;
        for (int i = 0; i < 8 && !got; i++) begin
            @(negedge clk);
            if (rdack || wrack) got = 1;
        end
        if (!got) begin
            vectors++;
            miscompares++;
            $display("FAIL ack_timeout: no ack, required one within 8 cycles");
            sb_q.delete();
        end
    endtask

    task automatic access(input logic [31:0] a, input logic rd,
                          input logic [31:0] wd, input logic [31:0] exp,
                          input logic er, input logic c2 = 1'b0,
                          input logic [31:0] exp2 = 32'h0);
        exp_t x;
        @(negedge clk);
        cs = 1'b1;
        rnw = rd;
        addr = a;
        wdata = wd;
        x.rd = rd;
        x.data = rd ? exp : 32'h0;
        x.err = er;
        x.chk2 = c2;
        x.data2 = rd ? exp2 : 32'h0;
        sb_q.push_back(x);
        wait_ack();
        cs = 1'b0;
        @(negedge clk);
    endtask

    task automatic link_fall_pulse();
        @(negedge clk);
        core_status[0] = 1'b0;
        @(negedge clk);
        core_status[0] = 1'b1;
    endtask

    function automatic vec_t mk(input logic [31:0] a, input logic rd,
                                input logic [31:0] wd, input logic [31:0] ex,
                                input logic er);
        vec_t v;
        v.addr = a;
        v.rd = rd;
        v.wdata = wd;
        v.exp = ex;
        v.err = er;
        return v;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] pat;
        exp_t x;

        tbl[0]  = mk(32'h00, 1, 0, 32'h0001_0000, 0);
        tbl[1]  = mk(32'h04, 1, 0, 32'h0, 0);
        tbl[2]  = mk(32'h0C, 1, 0, 32'h0, 0);
        tbl[3]  = mk(32'h10, 1, 0, 32'h0, 0);
        tbl[4]  = mk(32'h14, 1, 0, 32'h0, 0);
        tbl[5]  = mk(32'h18, 0, 32'hDEAD_BEEF, 0, 0);
        tbl[6]  = mk(32'h18, 1, 0, 32'hDEAD_BEEF, 0);
        tbl[7]  = mk(32'h04, 0, 32'hFFFF_FFFF, 0, 0);
        tbl[8]  = mk(32'h04, 1, 0, 32'h7, 0);
        tbl[9]  = mk(32'hFFFF_FFC7, 1, 0, 32'h7, 0);
        tbl[10] = mk(32'h10, 0, 32'hFFFF_FFFF, 0, 0);
        tbl[11] = mk(32'h10, 1, 0, 32'h3, 0);
        tbl[12] = mk(32'h08, 1, 0, 32'hA5, 0);
        tbl[13] = mk(32'h24, 1, 0, 32'h0, 1);
        tbl[14] = mk(32'h24, 0, 32'h1234_5678, 0, 1);
        tbl[15] = mk(32'h3C, 0, 32'h0, 0, 1);
        tbl[16] = mk(32'h18, 1, 0, 32'hDEAD_BEEF, 0);
        tbl[17] = mk(32'h08, 0, 32'h0, 0, 0);
        tbl[18] = mk(32'h08, 1, 0, 32'hA5, 0);
        tbl[19] = mk(32'h00, 1, 0, 32'h0001_0000, 0);

        rst = 1'b1;
        cs = 1'b0;
        rnw = 1'b0;
        addr = '0;
        wdata = '0;
        xgmacint = 1'b0;
        core_status = 8'hA5;
        repeat (3) @(negedge clk);
        chk("reset_ctl", {26'b0, irq, err, wrack, rdack, tx_en, rx_en},
            32'h0);
        chk("reset_lb_data", rd_data | {31'b0, lb}, 32'h0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 20; i++) begin
            access(tbl[i].addr, tbl[i].rd, tbl[i].wdata,
                   tbl[i].exp, tbl[i].err);
        end
        chk("unmapped_wr_ctrl", {29'b0, lb, rx_en, tx_en}, 32'h7);

        access(32'h04, 0, 32'h0, 0, 0);
        chk("ctrl_cleared", {29'b0, lb, rx_en, tx_en}, 32'h0);
        access(32'h04, 0, 32'h7, 0, 0);
        chk("ctrl_after_wrack", {29'b0, lb, rx_en, tx_en}, 32'h7);

        // cs held for four cycles: one ack only, in the first cycle.
        @(negedge clk);
        cs = 1'b1;
        rnw = 1'b1;
        addr = 32'h00;
        x = '{1'b1, 32'h0001_0000, 1'b0, 1'b0, 32'h0};
        sb_q.push_back(x);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            pat[i] = rdack;
        end
        cs = 1'b0;
        @(negedge clk);
        chk("hold_cs_ack_pattern", {28'b0, pat}, 32'h1);

        // Interrupt set from xgmacint, collision with W1C.
        @(negedge clk);
        xgmacint = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("irq_after_rise", {31'b0, irq}, 32'h1);
        access(32'h0C, 1, 0, 32'h1, 0);
        @(negedge clk);
        xgmacint = 1'b0;
        @(negedge clk);
        cs = 1'b1;
        rnw = 1'b0;
        addr = 32'h0C;
        wdata = 32'h1;
        x = '{1'b0, 32'h0, 1'b0, 1'b0, 32'h0};
        sb_q.push_back(x);
        @(negedge clk);
        xgmacint = 1'b1;
        cs = 1'b0;
        @(negedge clk);
        access(32'h0C, 1, 0, 32'h1, 0);
        access(32'h0C, 0, 32'h1, 0, 0);
        chk("irq_still_high", {31'b0, irq}, 32'h1);
        @(negedge clk);
        chk("irq_dropped", {31'b0, irq}, 32'h0);
        access(32'h0C, 1, 0, 32'h0, 0);

        // Link-down counter, clear collision, saturation on dut2.
        repeat (3) link_fall_pulse();
        access(32'h14, 1, 0, 32'h3, 0, 1, 32'h3);
        access(32'h0C, 1, 0, 32'h2, 0);
        chk("irq_link", {31'b0, irq}, 32'h1);
        @(negedge clk);
        cs = 1'b1;
        rnw = 1'b0;
        addr = 32'h14;
        wdata = 32'h0;
        x = '{1'b0, 32'h0, 1'b0, 1'b1, 32'h0};
        sb_q.push_back(x);
        @(negedge clk);
        core_status[0] = 1'b0;
        cs = 1'b0;
        @(negedge clk);
        core_status[0] = 1'b1;
        access(32'h14, 1, 0, 32'h1, 0, 1, 32'h1);
        repeat (3) link_fall_pulse();
        access(32'h14, 1, 0, 32'h4, 0, 1, 32'h3);

        // Reset in the ACK cycle of a SCRATCH write, cs held through it.
        xgmacint = 1'b0;
        repeat (2) @(negedge clk);
        cs = 1'b1;
        rnw = 1'b0;
        addr = 32'h18;
        wdata = 32'h0000_1234;
        x = '{1'b0, 32'h0, 1'b0, 1'b0, 32'h0};
        sb_q.push_back(x);
        @(negedge clk);
        rst = 1'b1;
        rnw = 1'b1;
        x = '{1'b1, 32'h0, 1'b0, 1'b1, 32'h0};
        sb_q.push_back(x);
        @(negedge clk);
        chk("rst_ack_suppressed", {29'b0, irq, rdack, wrack}, 32'h0);
        rst = 1'b0;
        wait_ack();
        cs = 1'b0;
        @(negedge clk);
        chk("ctrl_after_reset", {29'b0, lb, rx_en, tx_en}, 32'h0);
        access(32'h10, 1, 0, 32'h0, 0);
        access(32'h14, 1, 0, 32'h0, 0, 1, 32'h0);

        repeat (2) @(negedge clk);
        chk("scoreboard_drained", sb_q.size(), 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
